// File: rtl/sysu_bcd_scan4.sv
// rtl/sysu_bcd_scan4.sv - 4-digit multiplexed BCD scanner driving a 74LS48 decoder
module sysu_bcd_scan4 #(
  parameter int CLK_DIV    = 50000,
  parameter bit ZERO_BLANK = 1'b1
) (
  input  logic        CLK,
  input  logic        CLR_n,
  input  logic        EN,
  input  logic        LT_TEST_n,
  input  logic [15:0] DIN,
  input  logic        DIN_VLD,
  output logic        DIN_RDY,
  output logic        BCD_A,
  output logic        BCD_B,
  output logic        BCD_C,
  output logic        BCD_D,
  output logic        RBI_n,
  output logic        LT_n,
  output logic [3:0]  DIG_n,
  output logic        FRAME,
  output logic        BCD_ERR
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [15:0]      disp, disp_nxt;
  logic [15:0]      pend_data;
  logic             pend_full, pend_full_nxt;
  logic             tick, frame_tick, take, xfer;
  logic [3:0]       cur_digit;
  logic             blank_ok;
  logic             rbi_n_nxt, err_nxt;
  logic [3:0]       dig_n_nxt;
  logic [3:0]       bcd_q;

  assign DIN_RDY = CLR_n && !pend_full;
  assign BCD_A   = bcd_q[0];
  assign BCD_B   = bcd_q[1];
  assign BCD_C   = bcd_q[2];
  assign BCD_D   = bcd_q[3];

  always_comb begin
    tick        = EN && (div_cnt == DIV_LAST);
    frame_tick  = tick && (idx == 2'd0);
    div_cnt_nxt = div_cnt;
    if (EN) begin
      div_cnt_nxt = tick ? '0 : div_cnt + DIV_W'(1);
    end
    idx_nxt = tick ? idx - 2'd1 : idx;

    // With the scan stopped the display is dark, so the word can swap immediately.
    take          = DIN_VLD && DIN_RDY;
    xfer          = pend_full && (frame_tick || !EN);
    disp_nxt      = xfer ? pend_data : disp;
    pend_full_nxt = pend_full;
    if (take) begin
      pend_full_nxt = 1'b1;
    end else if (xfer) begin
      pend_full_nxt = 1'b0;
    end
  end

  // Outputs are computed from next-state so they line up with the slot they describe.
  always_comb begin
    cur_digit = disp_nxt[3:0];
    blank_ok  = 1'b0;
    case (idx_nxt)
      2'd3: begin
        cur_digit = disp_nxt[15:12];
        blank_ok  = 1'b1;
      end
      2'd2: begin
        cur_digit = disp_nxt[11:8];
        blank_ok  = (disp_nxt[15:12] == 4'd0);
      end
      2'd1: begin
        cur_digit = disp_nxt[7:4];
        blank_ok  = (disp_nxt[15:8] == 8'd0);
      end
      default: begin
        cur_digit = disp_nxt[3:0];
        blank_ok  = 1'b0;
      end
    endcase
    rbi_n_nxt = !(ZERO_BLANK && blank_ok);
    err_nxt   = (disp_nxt[15:12] > 4'd9) || (disp_nxt[11:8] > 4'd9) ||
                (disp_nxt[7:4] > 4'd9)   || (disp_nxt[3:0] > 4'd9);
    dig_n_nxt = 4'b1111;
    if (EN && (div_cnt_nxt != '0)) begin
      dig_n_nxt = ~(4'b0001 << idx_nxt);
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      div_cnt   <= '0;
      idx       <= 2'd3;
      disp      <= 16'h0000;
      pend_data <= 16'h0000;
      pend_full <= 1'b0;
      bcd_q     <= 4'd0;
      RBI_n     <= 1'b1;
      LT_n      <= 1'b1;
      DIG_n     <= 4'b1111;
      FRAME     <= 1'b0;
      BCD_ERR   <= 1'b0;
    end else begin
      div_cnt   <= div_cnt_nxt;
      idx       <= idx_nxt;
      disp      <= disp_nxt;
      pend_full <= pend_full_nxt;
      if (take) begin
        pend_data <= DIN;
      end
      bcd_q     <= cur_digit;
      RBI_n     <= rbi_n_nxt;
      LT_n      <= LT_TEST_n;
      DIG_n     <= dig_n_nxt;
      FRAME     <= frame_tick;
      BCD_ERR   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sysu_bcd_scan4.sv
// tb/tb_sysu_bcd_scan4.sv - scoreboard bench for sysu_bcd_scan4 with CLK_DIV=4
module tb_sysu_bcd_scan4;

  logic        CLK = 1'b0;
  logic        CLR_n, EN, LT_TEST_n, DIN_VLD;
  logic [15:0] DIN;
  logic        DIN_RDY, BCD_A, BCD_B, BCD_C, BCD_D, RBI_n, LT_n, FRAME, BCD_ERR;
  logic [3:0]  DIG_n;
  logic        nb_rdy, nb_a, nb_b, nb_c, nb_d, nb_rbi_n, nb_lt_n, nb_frame, nb_err;
  logic [3:0]  nb_dig_n;
  logic [3:0]  bcd;

  typedef struct packed {
    logic [3:0] dig;
    logic [3:0] bcd;
    logic       rbi;
    logic       err;
  } slot_t;

  slot_t       exp_q[$];
  slot_t       mon_e;
  logic [3:0]  prev_dig = 4'hF;
  int          n_vec = 0;
  int          n_miss = 0;
  int          nb_rbi_low = 0;
  int          hold_n;

  assign bcd = {BCD_D, BCD_C, BCD_B, BCD_A};

  sysu_bcd_scan4 #(.CLK_DIV(4), .ZERO_BLANK(1'b1)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .EN(EN), .LT_TEST_n(LT_TEST_n),
    .DIN(DIN), .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY),
    .BCD_A(BCD_A), .BCD_B(BCD_B), .BCD_C(BCD_C), .BCD_D(BCD_D),
    .RBI_n(RBI_n), .LT_n(LT_n), .DIG_n(DIG_n), .FRAME(FRAME), .BCD_ERR(BCD_ERR)
  );

  sysu_bcd_scan4 #(.CLK_DIV(4), .ZERO_BLANK(1'b0)) dut_nb (
    .CLK(CLK), .CLR_n(CLR_n), .EN(EN), .LT_TEST_n(LT_TEST_n),
    .DIN(DIN), .DIN_VLD(DIN_VLD), .DIN_RDY(nb_rdy),
    .BCD_A(nb_a), .BCD_B(nb_b), .BCD_C(nb_c), .BCD_D(nb_d),
    .RBI_n(nb_rbi_n), .LT_n(nb_lt_n), .DIG_n(nb_dig_n), .FRAME(nb_frame), .BCD_ERR(nb_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_frame(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (FRAME !== 1'b1 && n < 64);
    check(name, n, exp_n);
  endtask

  task automatic push_slot(input logic [3:0] dig, input logic [3:0] b, input logic rbi, input logic err);
    exp_q.push_back('{dig: dig, bcd: b, rbi: rbi, err: err});
  endtask

  // rbi holds the hand-derived RBI_n per slot, bit 3 = digit 3 (scanned first).
  task automatic push_frame(input logic [15:0] w, input logic [3:0] rbi, input logic err);
    push_slot(4'b0111, w[15:12], rbi[3], err);
    push_slot(4'b1011, w[11:8],  rbi[2], err);
    push_slot(4'b1101, w[7:4],   rbi[1], err);
    push_slot(4'b1110, w[3:0],   rbi[0], err);
  endtask

  // A digit is presented when DIG_n leaves the all-dark state.
  always @(negedge CLK) begin
    if (DIG_n !== 4'hF && prev_dig === 4'hF) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL slot_extra: got dig=%b bcd=%h rbi=%b err=%b, none expected",
                 DIG_n, bcd, RBI_n, BCD_ERR);
      end else begin
        mon_e = exp_q.pop_front();
        if ({DIG_n, bcd, RBI_n, BCD_ERR} !== mon_e) begin
          n_miss++;
          $display("FAIL slot: got dig=%b bcd=%h rbi=%b err=%b, expected dig=%b bcd=%h rbi=%b err=%b",
                   DIG_n, bcd, RBI_n, BCD_ERR, mon_e.dig, mon_e.bcd, mon_e.rbi, mon_e.err);
        end
      end
    end
    prev_dig = DIG_n;
    if (CLR_n === 1'b1 && nb_rbi_n !== 1'b1) nb_rbi_low++;
  end

  initial begin
    CLR_n = 1'b0; EN = 1'b1; LT_TEST_n = 1'b1; DIN = 16'h0000; DIN_VLD = 1'b0;
    push_frame(16'h0000, 4'b0001, 1'b0);
    push_frame(16'h0000, 4'b0001, 1'b0);
    #1 check("rdy_in_reset", DIN_RDY, 1'b0);
    step();
    step();
    check("rst_dig", DIG_n, 4'hF);
    check("rst_bcd", bcd, 4'h0);
    check("rst_rbi", RBI_n, 1'b1);
    check("rst_lt", LT_n, 1'b1);
    check("rst_frame", FRAME, 1'b0);
    check("rst_err", BCD_ERR, 1'b0);
    CLR_n = 1'b1;
    #1 check("rdy_release", DIN_RDY, 1'b1);
    wait_frame("frame_first", 16);

    // word accepted mid-frame, shown from the next frame
    push_frame(16'h0042, 4'b0001, 1'b0);
    repeat (5) step();
    DIN = 16'h0042; DIN_VLD = 1'b1;
    #1 check("rdy_before_0042", DIN_RDY, 1'b1);
    step();
    DIN_VLD = 1'b0;
    check("rdy_drop_0042", DIN_RDY, 1'b0);
    wait_frame("frame_0042", 10);
    check("rdy_free_0042", DIN_RDY, 1'b1);

    // back-to-back words, second held off until the boundary
    push_frame(16'h1000, 4'b0111, 1'b0);
    push_frame(16'h2000, 4'b0111, 1'b0);
    DIN = 16'h1000; DIN_VLD = 1'b1;
    step();
    check("rdy_full_1000", DIN_RDY, 1'b0);
    DIN = 16'h2000;
    hold_n = 0;
    do begin
      step();
      hold_n++;
    end while (DIN_RDY !== 1'b1 && hold_n < 40);
    check("holdoff_2000", hold_n, 15);
    check("holdoff_frame", FRAME, 1'b1);
    step();
    DIN_VLD = 1'b0;
    check("rdy_full_2000", DIN_RDY, 1'b0);
    wait_frame("frame_2000", 15);
    check("rdy_free_2000", DIN_RDY, 1'b1);

    // invalid digit forwarded raw, then EN=0 swap
    push_slot(4'b0111, 4'h0, 1'b0, 1'b1);
    push_slot(4'b0111, 4'h9, 1'b0, 1'b0);
    push_slot(4'b1011, 4'h9, 1'b1, 1'b0);
    push_slot(4'b1101, 4'h9, 1'b1, 1'b0);
    push_slot(4'b1110, 4'h9, 1'b1, 1'b0);
    DIN = 16'h0A05; DIN_VLD = 1'b1;
    step();
    DIN_VLD = 1'b0;
    check("err_before", BCD_ERR, 1'b0);
    wait_frame("frame_0a05", 15);
    check("err_after", BCD_ERR, 1'b1);

    DIN = 16'h9999; DIN_VLD = 1'b1;
    step();
    EN = 1'b0; DIN_VLD = 1'b0;
    step();
    check("en_off_dark", DIG_n, 4'hF);
    check("en_off_bcd", bcd, 4'h9);
    check("en_off_err", BCD_ERR, 1'b0);
    check("en_off_rdy", DIN_RDY, 1'b1);
    step();
    check("en_off_hold", DIG_n, 4'hF);
    EN = 1'b1;
    wait_frame("frame_resume", 15);

    // lamp test while scanning, then reset with a word pending
    push_slot(4'b0111, 4'h9, 1'b0, 1'b0);
    push_slot(4'b1011, 4'h9, 1'b1, 1'b0);
    DIN = 16'h1234; DIN_VLD = 1'b1; LT_TEST_n = 1'b0;
    step();
    DIN_VLD = 1'b0; LT_TEST_n = 1'b1;
    check("lt_on", LT_n, 1'b0);
    check("lt_scan", DIG_n, 4'b0111);
    check("rdy_full_1234", DIN_RDY, 1'b0);
    step();
    check("lt_off", LT_n, 1'b1);
    repeat (4) step();
    CLR_n = 1'b0;
    #1 check("rdy_clr", DIN_RDY, 1'b0);
    step();
    check("clr_dig", DIG_n, 4'hF);
    check("clr_bcd", bcd, 4'h0);
    check("clr_rbi", RBI_n, 1'b1);
    check("clr_frame", FRAME, 1'b0);
    check("clr_err", BCD_ERR, 1'b0);
    push_frame(16'h0000, 4'b0001, 1'b0);
    push_frame(16'h0000, 4'b0001, 1'b0);
    CLR_n = 1'b1;
    #1 check("rdy_after_clr", DIN_RDY, 1'b1);
    wait_frame("frame_after_clr", 16);
    wait_frame("frame_period", 16);
    step();
    check("queue_drained", exp_q.size(), 0);
    check("nb_rbi_high", nb_rbi_low, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
